lfsr_shift_engine: RTL
======================

Name: lfsr_shift_engine

Overview:
Parametrised shift-register / LFSR engine, the next generation of the team's 8-bit LFSR shifter. It adds generic width and tap mask, serial shift and rotate modes, and a multi-step burst run with busy/done handshake. It also detects and optionally recovers from all-zero lock-up. It sits as a pseudo-random / serial-data source under a simple command interface.

Parameters:
WIDTH, 8, register width (>=2)
TAPS, 'h1D, feedback tap mask (WIDTH bits); bit i set => data[i] feeds parity
SEED, 'h01, value loaded on lock-up recovery (must be nonzero)
AUTO_SEED, 0, 1 => LFSR step on all-zero state reloads SEED instead of stepping
CNT_W, 8, width of burst step count

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
en  in  1  command strobe; cmd sampled only when en=1
cmd  in  3  command: 000 CLEAR, 001 LOAD, 010 STEP, 011 HOLD, 100 SHR, 101 SHL, 110 ROR, 111 BURST
din  in  WIDTH  load value for LOAD
sin  in  1  serial input for SHR/SHL
cnt  in  CNT_W  step count for BURST
data  out  WIDTH  register contents
sout  out  1  continuous data[0]
busy  out  1  burst in progress
done  out  1  one-cycle pulse at burst completion
lockup  out  1  sticky: LFSR step attempted on all-zero state

Behaviour:
- Reset is synchronous and active-high on rst, sampled at posedge clk, highest priority: data=0, busy=0, done=0, lockup=0, FSM=IDLE, remaining=0.
- LFSR step function: fb = XOR-reduce(data & TAPS); next = {fb, data[WIDTH-1:1]}.
  - If data==0: lockup<=1; data<=SEED if AUTO_SEED else stays 0.
- FSM states: IDLE, RUN.
- IDLE, en=0: data holds.
- IDLE, en=1: command applied at that edge.
  - CLEAR: data<=0, lockup<=0.
  - LOAD: data<=din, lockup<=0.
  - STEP: one LFSR step.
  - HOLD: no change.
  - SHR: data<={sin, data[WIDTH-1:1]}.
  - SHL: data<={data[WIDTH-2:0], sin}.
  - ROR: data<={data[0], data[WIDTH-1:1]}.
  - BURST, cnt=0: done<=1 at that edge, busy stays 0, data unchanged.
  - BURST, cnt=N>0: busy<=1, remaining<=N, go RUN; no step on the accept edge.
- RUN: each edge performs one LFSR step and decrements remaining.
  - On the edge where remaining==1: busy<=0, done<=1, go IDLE.
  - Result: exactly N steps; done is high in the cycle after the Nth step edge; busy is low in that same cycle.
- RUN with en=1 and cmd=CLEAR: abort. data<=0, lockup<=0, busy<=0, no done pulse, go IDLE.
- RUN with any other en=1 command: ignored and not queued.
- done is high for exactly one cycle, otherwise 0.
- BURST presented in the cycle done is high is accepted normally, giving back-to-back bursts.
- lockup stays set until CLEAR, LOAD, abort or rst.
  - It is not set by SHR/SHL/ROR on zero data.
  - During a burst with AUTO_SEED=0 and zero data, lockup sets and data stays 0 for the remaining steps; the burst still completes with done.
- All arithmetic is unsigned. remaining is CNT_W bits; max burst is 2^CNT_W-1 steps.

Decomposition:
- Shared package lfsr_pkg holds:
  - the cmd encoding constants (CMD_CLEAR..CMD_BURST);
  - the FSM state typedef (IDLE, RUN);
  - a parity/step function parametrised on WIDTH and TAPS.
- One natural sub-module: lfsr_step_comb, a combinational next-state for STEP including AUTO_SEED handling and the lock-up indication. It is reused by the IDLE STEP path and the RUN path.

Test Plan:
- rst=1 for one edge after arbitrary activity -> data=0x00, busy=0, done=0, lockup=0 next cycle.
- LOAD 0x01, then STEP x5 -> data sequence 0x80, 0x40, 0x20, 0x10, 0x88.
- LOAD 0x01, BURST cnt=5:
  - busy=1 for 5 cycles;
  - done pulses once in the cycle busy falls;
  - data=0x88;
  - LOAD issued mid-burst is ignored.
- LOAD 0xA5:
  - SHR sin=1 -> 0xD2;
  - LOAD 0xA5, SHL sin=0 -> 0x4A;
  - LOAD 0xA4, ROR -> 0x52;
  - sout tracks data[0].
- CLEAR then STEP:
  - AUTO_SEED=0 -> data=0x00, lockup=1;
  - AUTO_SEED=1 -> data=0x01, lockup=1;
  - subsequent LOAD 0x33 -> lockup=0.
- BURST cnt=0 -> done one cycle, busy never high, data unchanged.
- BURST cnt=10 aborted by CLEAR after 3 cycles -> data=0, busy=0, no done.

Source files
------------

// File: rtl/lfsr_pkg.sv
// ----------------------------------------------------------------------------
// lfsr_pkg
// Shared definitions for the LFSR / shift-register engine.
//   - Command encodings presented on the engine's cmd input.
//   - Two-state sequencer type (IDLE waits for commands, RUN executes a burst).
//   - Tap parity helper used to form the LFSR feedback bit.
// ----------------------------------------------------------------------------
package lfsr_pkg;

    localparam logic [2:0] CMD_CLEAR = 3'b000;
    localparam logic [2:0] CMD_LOAD  = 3'b001;
    localparam logic [2:0] CMD_STEP  = 3'b010;
    localparam logic [2:0] CMD_HOLD  = 3'b011;
    localparam logic [2:0] CMD_SHR   = 3'b100;
    localparam logic [2:0] CMD_SHL   = 3'b101;
    localparam logic [2:0] CMD_ROR   = 3'b110;
    localparam logic [2:0] CMD_BURST = 3'b111;

    // Widest register the parity helper can handle; callers zero-extend
    // their data and tap mask to this width.
    localparam int PARITY_MAX_W = 64;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } lfsrState_t;

    // Feedback bit: XOR of every data bit whose tap is set. Zero-extended
    // upper bits contribute nothing, so one helper serves every width.
    function automatic logic tapParity(input logic [PARITY_MAX_W-1:0] value,
                                       input logic [PARITY_MAX_W-1:0] taps);
        return ^(value & taps);
    endfunction

endpackage

// File: rtl/lfsr_step_comb.sv
// ----------------------------------------------------------------------------
// lfsr_step_comb
// Purely combinational single LFSR step, shared by the single-step command
// and by every cycle of a burst.
// Ports:
//   data_i    current register contents
//   next_o    register contents after one step
//   lockup_o  high when the step was attempted on the all-zero state
// WIDTH must not exceed lfsr_pkg::PARITY_MAX_W.
// ----------------------------------------------------------------------------
module lfsr_step_comb
    import lfsr_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] TAPS      = WIDTH'('h1D),
    parameter logic [WIDTH-1:0] SEED      = WIDTH'('h01),
    parameter int               AUTO_SEED = 0
) (
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] next_o,
    output logic             lockup_o
);

    logic feedback;

    // Normal step shifts right and inserts the tap parity at the top. The
    // all-zero state is a fixed point of the LFSR, so it is flagged and,
    // when AUTO_SEED is set, replaced by the seed to restart the sequence.
    always_comb begin
        feedback = tapParity(PARITY_MAX_W'(data_i), PARITY_MAX_W'(TAPS));
        next_o   = {feedback, data_i[WIDTH-1:1]};
        lockup_o = 1'b0;
        if (data_i == '0) begin
            lockup_o = 1'b1;
            next_o   = (AUTO_SEED != 0) ? SEED : '0;
        end
    end

endmodule

// File: rtl/lfsr_shift_engine.sv
// ----------------------------------------------------------------------------
// lfsr_shift_engine
// Parametrised shift-register / LFSR engine with a command interface.
// Ports:
//   clk     rising-edge clock
//   rst     synchronous active-high reset
//   en      command strobe, cmd is acted on only while en is high
//   cmd     CLEAR/LOAD/STEP/HOLD/SHR/SHL/ROR/BURST (see lfsr_pkg)
//   din     value for LOAD
//   sin     serial input for SHR/SHL
//   cnt     number of LFSR steps for BURST
//   data    register contents
//   sout    data[0]
//   busy    burst in progress
//   done    one-cycle pulse when a burst finishes (or a zero-length burst)
//   lockup  sticky flag: an LFSR step hit the all-zero state
// ----------------------------------------------------------------------------
module lfsr_shift_engine
    import lfsr_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] TAPS      = WIDTH'('h1D),
    parameter logic [WIDTH-1:0] SEED      = WIDTH'('h01),
    parameter int               AUTO_SEED = 0,
    parameter int               CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       cmd,
    input  logic [WIDTH-1:0] din,
    input  logic             sin,
    input  logic [CNT_W-1:0] cnt,
    output logic [WIDTH-1:0] data,
    output logic             sout,
    output logic             busy,
    output logic             done,
    output logic             lockup
);

    lfsrState_t       state_q,     state_d;
    logic [WIDTH-1:0] data_q,      data_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic             done_q,      done_d;
    logic             lockup_q,    lockup_d;

    logic [WIDTH-1:0] stepNext;
    logic             stepLockup;

    lfsr_step_comb #(
        .WIDTH     (WIDTH),
        .TAPS      (TAPS),
        .SEED      (SEED),
        .AUTO_SEED (AUTO_SEED)
    ) u_step (
        .data_i   (data_q),
        .next_o   (stepNext),
        .lockup_o (stepLockup)
    );

    // State register. Reset clears everything and wins over any command.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            data_q      <= '0;
            remaining_q <= '0;
            done_q      <= 1'b0;
            lockup_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            remaining_q <= remaining_d;
            done_q      <= done_d;
            lockup_q    <= lockup_d;
        end
    end

    // Command decode and burst sequencing. done defaults low so it can only
    // ever be a single-cycle pulse. While a burst runs, only CLEAR is
    // honoured (as an abort); every other command is dropped.
    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        remaining_d = remaining_q;
        done_d      = 1'b0;
        lockup_d    = lockup_q;

        unique case (state_q)
            IDLE: begin
                if (en) begin
                    unique case (cmd)
                        CMD_CLEAR: begin
                            data_d   = '0;
                            lockup_d = 1'b0;
                        end
                        CMD_LOAD: begin
                            data_d   = din;
                            lockup_d = 1'b0;
                        end
                        CMD_STEP: begin
                            data_d = stepNext;
                            if (stepLockup) lockup_d = 1'b1;
                        end
                        CMD_HOLD: ;
                        CMD_SHR: data_d = {sin, data_q[WIDTH-1:1]};
                        CMD_SHL: data_d = {data_q[WIDTH-2:0], sin};
                        CMD_ROR: data_d = {data_q[0], data_q[WIDTH-1:1]};
                        CMD_BURST: begin
                            // A zero-length burst completes immediately.
                            if (cnt == '0) begin
                                done_d = 1'b1;
                            end else begin
                                remaining_d = cnt;
                                state_d     = RUN;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (en && (cmd == CMD_CLEAR)) begin
                    data_d      = '0;
                    lockup_d    = 1'b0;
                    remaining_d = '0;
                    state_d     = IDLE;
                end else begin
                    data_d      = stepNext;
                    if (stepLockup) lockup_d = 1'b1;
                    remaining_d = remaining_q - {{(CNT_W-1){1'b0}}, 1'b1};
                    if (remaining_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign data   = data_q;
    assign sout   = data_q[0];
    assign busy   = (state_q == RUN);
    assign done   = done_q;
    assign lockup = lockup_q;

endmodule
